add_tree: RTL and testbench

ADD_TREE -- requirements
Module: add_tree

---
 rtl/add_tree_pkg.sv | 31 +++
 rtl/add_tree_level.sv | 48 ++++
 rtl/add_tree.sv | 74 +++++++
 tb/tb_add_tree.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/add_tree_pkg.sv
// Shared sizing helpers for the pipelined adder tree: level count, per-level
// element count and bit offsets of each level inside the top-level flat bus.
package add_tree_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int MAX_N     = 64;

    function automatic int level_count(input int n);
        return $clog2(n);
    endfunction

    // ceil(n / 2^k), computed by repeated ceiling halving
    function automatic int elem_count(input int n, input int k);
        int c;
        c = n;
        for (int j = 0; j < k; j++) begin
            c = (c + 32'sd1) / 32'sd2;
        end
        return c;
    endfunction

    function automatic int bus_offset(input int n, input int w, input int k);
        int off;
        off = 32'sd0;
        for (int j = 0; j < k; j++) begin
            off = off + elem_count(n, j) * (w + j);
        end
        return off;
    endfunction

endpackage

// File: rtl/add_tree_level.sv
// One registered pairwise-add level of the adder tree; an odd trailing element
// is zero-extended and registered without an adder. Carries its valid bit.
module add_tree_level
    import add_tree_pkg::*;
#(
    parameter int IN_W   = 6,
    parameter int IN_CNT = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [IN_CNT*IN_W-1:0]                din,
    input  logic                                  valid_in,
    output logic [((IN_CNT+1)/2)*(IN_W+1)-1:0]    dout,
    output logic                                  valid_out
);

    localparam int OUT_W   = IN_W + 1;
    localparam int OUT_CNT = (IN_CNT + 1) / 2;

    logic [OUT_CNT*OUT_W-1:0] sum_s;
    logic [OUT_CNT*OUT_W-1:0] data_r;
    logic                     valid_r;

    for (genvar i = 0; i < OUT_CNT; i++) begin : g_pair
        if (2*i + 1 < IN_CNT) begin : g_add
            assign sum_s[i*OUT_W +: OUT_W] = OUT_W'(din[(2*i)*IN_W +: IN_W])
                                           + OUT_W'(din[(2*i+1)*IN_W +: IN_W]);
        end else begin : g_pass
            assign sum_s[i*OUT_W +: OUT_W] = OUT_W'(din[(2*i)*IN_W +: IN_W]);
        end
    end

    // Level register: data advances on every enabled edge regardless of valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (en) begin
            data_r  <= sum_s;
            valid_r <= valid_in;
        end
    end

    assign dout      = data_r;
    assign valid_out = valid_r;

endmodule

// File: rtl/add_tree.sv
// Pipelined unsigned adder tree summing N operands over $clog2(N) levels.
// Optional macro ADD_TREE_OUT_REG_EN adds one output register stage.
module add_tree
    import add_tree_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int N     = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [WIDTH-1:0]                 in [N-1:0],
    input  logic                             valid_in,
    output logic [WIDTH+level_count(N)-1:0]  out,
    output logic                             valid_out
);

    localparam int L     = level_count(N);
    localparam int OW    = WIDTH + L;
    localparam int TOTAL = bus_offset(N, WIDTH, L + 1);

    // All levels packed back to back; level k starts at bus_offset(N, WIDTH, k)
    logic [TOTAL-1:0] bus_s;
    logic [L:0]       vbus_s;

    for (genvar i = 0; i < N; i++) begin : g_in
        assign bus_s[i*WIDTH +: WIDTH] = in[i];
    end
    assign vbus_s[0] = valid_in;

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int IN_OFF  = bus_offset(N, WIDTH, k - 1);
        localparam int IN_CNT  = elem_count(N, k - 1);
        localparam int IN_W    = WIDTH + k - 1;
        localparam int OUT_OFF = bus_offset(N, WIDTH, k);
        localparam int OUT_LEN = elem_count(N, k) * (WIDTH + k);

        add_tree_level #(
            .IN_W   (IN_W),
            .IN_CNT (IN_CNT)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .din       (bus_s[IN_OFF +: IN_CNT*IN_W]),
            .valid_in  (vbus_s[k-1]),
            .dout      (bus_s[OUT_OFF +: OUT_LEN]),
            .valid_out (vbus_s[k])
        );
    end

`ifdef ADD_TREE_OUT_REG_EN
    logic [OW-1:0] out_r;
    logic          valid_r;

    // Extra output stage, gated and reset exactly like the tree levels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_r   <= '0;
            valid_r <= 1'b0;
        end else if (en) begin
            out_r   <= bus_s[bus_offset(N, WIDTH, L) +: OW];
            valid_r <= vbus_s[L];
        end
    end

    assign out       = out_r;
    assign valid_out = valid_r;
`else
    assign out       = bus_s[bus_offset(N, WIDTH, L) +: OW];
    assign valid_out = vbus_s[L];
`endif

endmodule

// File: tb/tb_add_tree.sv
// Directed self-checking bench for add_tree: a WIDTH=6,N=5 instance plus a
// WIDTH=6,N=8 instance; latency expectations follow ADD_TREE_OUT_REG_EN.
module tb_add_tree;

`ifdef ADD_TREE_OUT_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [5:0] din5 [4:0];
    logic [5:0] din8 [7:0];
    logic       valid_in5;
    logic       valid_in8;
    logic [8:0] out5;
    logic [8:0] out8;
    logic       valid_out5;
    logic       valid_out8;

    int checks = 0;
    int errors = 0;

    add_tree #(.WIDTH(6), .N(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in        (din5),
        .valid_in  (valid_in5),
        .out       (out5),
        .valid_out (valid_out5)
    );

    add_tree #(.WIDTH(6), .N(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in        (din8),
        .valid_in  (valid_in8),
        .out       (out8),
        .valid_out (valid_out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set5(input int a, input int b, input int c, input int d, input int e);
        din5[0] = 6'(a); din5[1] = 6'(b); din5[2] = 6'(c); din5[3] = 6'(d); din5[4] = 6'(e);
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        valid_in5 = 1'b0;
        valid_in8 = 1'b0;
        set5(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) din8[i] = 6'd0;

        // reset state
        tick();
        tick();
        check("rst_out5", 32'(out5), 32'd0);
        check("rst_valid5", 32'(valid_out5), 32'd0);
        check("rst_out8", 32'(out8), 32'd0);
        check("rst_valid8", 32'(valid_out8), 32'd0);
        rst = 1'b1;
        tick();

        // sum 1..5 on N=5 and 1..8 on N=8, latency check
        set5(1, 2, 3, 4, 5);
        for (int i = 0; i < 8; i++) din8[i] = 6'(i + 1);
        valid_in5 = 1'b1;
        valid_in8 = 1'b1;
        tick();
        valid_in5 = 1'b0;
        valid_in8 = 1'b0;
        set5(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) din8[i] = 6'd0;
        for (int c = 1; c < LAT; c++) begin
            check("lat_early5", 32'(valid_out5), 32'd0);
            check("lat_early8", 32'(valid_out8), 32'd0);
            tick();
        end
        check("basic_valid5", 32'(valid_out5), 32'd1);
        check("basic_sum5", 32'(out5), 32'd15);
        check("basic_valid8", 32'(valid_out8), 32'd1);
        check("basic_sum8", 32'(out8), 32'd36);
        tick();
        check("pulse_end5", 32'(valid_out5), 32'd0);
        check("pulse_end8", 32'(valid_out8), 32'd0);

        // all-max operands
        set5(63, 63, 63, 63, 63);
        valid_in5 = 1'b1;
        tick();
        valid_in5 = 1'b0;
        set5(0, 0, 0, 0, 0);
        for (int c = 1; c < LAT; c++) tick();
        check("max_valid", 32'(valid_out5), 32'd1);
        check("max_sum", 32'(out5), 32'd315);
        tick();

        // back-to-back sets
        set5(1, 1, 1, 1, 1);
        valid_in5 = 1'b1;
        tick();
        set5(2, 2, 2, 2, 2);
        tick();
        set5(0, 0, 0, 0, 0);
        tick();
        valid_in5 = 1'b0;
        for (int c = 3; c < LAT; c++) tick();
        check("b2b_v0", 32'(valid_out5), 32'd1);
        check("b2b_s0", 32'(out5), 32'd5);
        tick();
        check("b2b_v1", 32'(valid_out5), 32'd1);
        check("b2b_s1", 32'(out5), 32'd10);
        tick();
        check("b2b_v2", 32'(valid_out5), 32'd1);
        check("b2b_s2", 32'(out5), 32'd0);
        tick();
        check("b2b_end", 32'(valid_out5), 32'd0);

        // en=0 for 4 cycles mid-pipe; inputs during the stall must be ignored
        set5(1, 2, 3, 4, 5);
        valid_in5 = 1'b1;
        tick();
        valid_in5 = 1'b0;
        set5(0, 0, 0, 0, 0);
        tick();
        en = 1'b0;
        valid_in5 = 1'b1;
        set5(63, 63, 63, 63, 63);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("stall_hold", 32'(valid_out5), 32'd0);
        end
        en = 1'b1;
        valid_in5 = 1'b0;
        set5(0, 0, 0, 0, 0);
        for (int c = 2; c < LAT; c++) begin
            check("stall_early", 32'(valid_out5), 32'd0);
            tick();
        end
        check("stall_valid", 32'(valid_out5), 32'd1);
        check("stall_sum", 32'(out5), 32'd15);
        en = 1'b0;
        tick();
        check("freeze_valid", 32'(valid_out5), 32'd1);
        check("freeze_sum", 32'(out5), 32'd15);
        en = 1'b1;
        tick();
        check("unfreeze_valid", 32'(valid_out5), 32'd0);
        for (int c = 0; c < LAT + 1; c++) begin
            tick();
            check("no_ghost", 32'(valid_out5), 32'd0);
        end

        // reset one cycle after a valid pulse discards the in-flight set
        set5(1, 2, 3, 4, 5);
        valid_in5 = 1'b1;
        tick();
        valid_in5 = 1'b0;
        set5(0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_out5), 32'd0);
        check("mid_rst_out", 32'(out5), 32'd0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            check("post_rst_valid", 32'(valid_out5), 32'd0);
            check("post_rst_out", 32'(out5), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
